// File: rtl/traffic_light_monitor_if.sv
// Lights-bus bundle between the light controller (master) and traffic_light_monitor (slave).
// Carries the observed lights, the clear pulse and all monitor status outputs.
interface traffic_light_monitor_if #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned DWELL_W = 6
) ();

  logic [2:0]         lights;
  logic               clear_i;
  logic [2:0]         phase_o;
  logic               locked_o;
  logic               err_code_o;
  logic               err_seq_o;
  logic               err_dwell_o;
  logic [CNT_W-1:0]   cycles_o;
  logic [DWELL_W-1:0] dwell_o;

  modport master (
    output lights, clear_i,
    input  phase_o, locked_o, err_code_o, err_seq_o, err_dwell_o, cycles_o, dwell_o
  );

  modport slave (
    input  lights, clear_i,
    output phase_o, locked_o, err_code_o, err_seq_o, err_dwell_o, cycles_o, dwell_o
  );

endinterface

// File: rtl/traffic_light_monitor.sv
// Receive-side checker for the one-hot lights bus {red,yellow,green}: tracks green->yellow->red order,
// counts completed cycles and raises sticky errors. Optional dwell checking: define DWELL_CHECK_EN.
module traffic_light_monitor #(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned DWELL_W   = 6,
  parameter int unsigned MIN_DWELL = 1,
  parameter int unsigned MAX_DWELL = 16
) (
  input  logic                    clock,
  input  logic                    reset_n,
  traffic_light_monitor_if.slave  bus
);

  localparam logic [2:0] CODE_RED    = 3'b100;
  localparam logic [2:0] CODE_YELLOW = 3'b010;
  localparam logic [2:0] CODE_GREEN  = 3'b001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RED,
    ST_YELLOW,
    ST_GREEN,
    ST_FAULT
  } state_t;

  if (MIN_DWELL > MAX_DWELL || MAX_DWELL >= (2 ** DWELL_W)) begin : g_bad_cfg
    $error("traffic_light_monitor: need MIN_DWELL <= MAX_DWELL < 2**DWELL_W");
  end

  // Legal codes map to their phase state; anything else maps to ST_IDLE.
  function automatic state_t code_to_state(input logic [2:0] code);
    state_t s;
    case (code)
      CODE_RED:    s = ST_RED;
      CODE_YELLOW: s = ST_YELLOW;
      CODE_GREEN:  s = ST_GREEN;
      default:     s = ST_IDLE;
    endcase
    return s;
  endfunction

  function automatic logic [2:0] state_to_code(input state_t s);
    logic [2:0] c;
    case (s)
      ST_RED:    c = CODE_RED;
      ST_YELLOW: c = CODE_YELLOW;
      ST_GREEN:  c = CODE_GREEN;
      default:   c = 3'b000;
    endcase
    return c;
  endfunction

  function automatic state_t successor(input state_t s);
    state_t n;
    case (s)
      ST_GREEN:  n = ST_YELLOW;
      ST_YELLOW: n = ST_RED;
      ST_RED:    n = ST_GREEN;
      default:   n = ST_IDLE;
    endcase
    return n;
  endfunction

  state_t             state_q, state_n;
  logic [DWELL_W-1:0] dwell_q, dwell_n;
  logic [CNT_W-1:0]   cycles_q, cycles_n;
  logic               err_code_q, err_code_n;
  logic               err_seq_q, err_seq_n;
  logic               set_code, set_seq, set_dwell;
  logic               code_legal;
  state_t             code_state;

`ifdef DWELL_CHECK_EN
  logic               err_dwell_q, err_dwell_n;
  logic               dwell_hit_q, dwell_hit_n;
`endif

  always_comb begin
    state_n    = state_q;
    dwell_n    = dwell_q;
    cycles_n   = cycles_q;
    set_code   = 1'b0;
    set_seq    = 1'b0;
    set_dwell  = 1'b0;
    code_state = code_to_state(bus.lights);
    code_legal = (code_state != ST_IDLE);
`ifdef DWELL_CHECK_EN
    dwell_hit_n = dwell_hit_q;
`endif

    case (state_q)
      ST_IDLE: begin
        dwell_n = '0;
        if (code_legal) begin
          state_n = code_state;
          dwell_n = DWELL_W'(1);
`ifdef DWELL_CHECK_EN
          dwell_hit_n = 1'b0;
`endif
        end else begin
          set_code = 1'b1;
        end
      end

      ST_RED, ST_YELLOW, ST_GREEN: begin
        if (!code_legal) begin
          set_code = 1'b1;
          state_n  = ST_FAULT;
          dwell_n  = '0;
        end else if (code_state == state_q) begin
          dwell_n = (dwell_q == '1) ? dwell_q : dwell_q + 1'b1;
`ifdef DWELL_CHECK_EN
          // Dwell is about to pass MAX_DWELL; the hit flag keeps this to one report per phase.
          if (dwell_q >= DWELL_W'(MAX_DWELL) && !dwell_hit_q) begin
            set_dwell   = 1'b1;
            dwell_hit_n = 1'b1;
          end
`endif
        end else if (code_state == successor(state_q)) begin
          state_n = code_state;
          dwell_n = DWELL_W'(1);
          if (state_q == ST_RED) begin
            cycles_n = cycles_q + 1'b1;
          end
`ifdef DWELL_CHECK_EN
          dwell_hit_n = 1'b0;
          if (dwell_q < DWELL_W'(MIN_DWELL)) begin
            set_dwell = 1'b1;
          end
`endif
        end else begin
          set_seq = 1'b1;
          state_n = ST_FAULT;
          dwell_n = '0;
        end
      end

      ST_FAULT: begin
        dwell_n = '0;
        if (bus.clear_i) begin
          state_n = ST_IDLE;
        end
      end

      default: begin
        state_n = ST_IDLE;
        dwell_n = '0;
      end
    endcase

    // A freshly detected error takes priority over a clear in the same cycle.
    err_code_n = set_code | (err_code_q & ~bus.clear_i);
    err_seq_n  = set_seq  | (err_seq_q  & ~bus.clear_i);
`ifdef DWELL_CHECK_EN
    err_dwell_n = set_dwell | (err_dwell_q & ~bus.clear_i);
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      dwell_q    <= '0;
      cycles_q   <= '0;
      err_code_q <= 1'b0;
      err_seq_q  <= 1'b0;
    end else begin
      state_q    <= state_n;
      dwell_q    <= dwell_n;
      cycles_q   <= cycles_n;
      err_code_q <= err_code_n;
      err_seq_q  <= err_seq_n;
    end
  end

`ifdef DWELL_CHECK_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_dwell_q <= 1'b0;
      dwell_hit_q <= 1'b0;
    end else begin
      err_dwell_q <= err_dwell_n;
      dwell_hit_q <= dwell_hit_n;
    end
  end

  assign bus.err_dwell_o = err_dwell_q;
`else
  assign bus.err_dwell_o = 1'b0;
`endif

  assign bus.phase_o    = state_to_code(state_q);
  assign bus.locked_o   = (state_q == ST_RED) || (state_q == ST_YELLOW) || (state_q == ST_GREEN);
  assign bus.err_code_o = err_code_q;
  assign bus.err_seq_o  = err_seq_q;
  assign bus.cycles_o   = cycles_q;
  assign bus.dwell_o    = dwell_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Self-checking bench for traffic_light_monitor: directed scenarios plus randomized lights/clear
// traffic compared against a phase-index reference model.
module tb_traffic_light_monitor;

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned DWELL_W = 6;
`ifdef DWELL_CHECK_EN
  localparam int unsigned MIN_D = 2;
  localparam int unsigned MAX_D = 4;
`else
  localparam int unsigned MIN_D = 1;
  localparam int unsigned MAX_D = 16;
`endif

  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b100;

  logic clock;
  logic reset_n;
  int   checks;
  int   errors;

  traffic_light_monitor_if #(.CNT_W(CNT_W), .DWELL_W(DWELL_W)) bus ();

  traffic_light_monitor #(
    .CNT_W    (CNT_W),
    .DWELL_W  (DWELL_W),
    .MIN_DWELL(MIN_D),
    .MAX_DWELL(MAX_D)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: mode 0=idle 1=tracking 2=fault; phase index 0=green 1=yellow 2=red,
  // legal order is index+1 modulo 3 and one-hot code is 1<<index.
  int m_mode, m_ph, m_dwell, m_cycles;
  bit m_ec, m_es, m_ed, m_hit;

  function automatic int code_idx(input logic [2:0] l);
    int idx;
    idx = -1;
    for (int k = 0; k < 3; k++) if (l == 3'(1 << k)) idx = k;
    return idx;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_ph = 0; m_dwell = 0; m_cycles = 0;
    m_ec = 0; m_es = 0; m_ed = 0; m_hit = 0;
  endtask

  task automatic model_step(input logic [2:0] l, input logic c);
    int idx;
    bit sc, ss, sd;
    idx = code_idx(l);
    sc = 0; ss = 0; sd = 0;
    if (m_mode == 0) begin
      if (idx >= 0) begin m_mode = 1; m_ph = idx; m_dwell = 1; m_hit = 0; end
      else sc = 1;
    end else if (m_mode == 1) begin
      if (idx < 0) begin
        sc = 1; m_mode = 2; m_dwell = 0;
      end else if (idx == m_ph) begin
        if (m_dwell + 1 > int'(MAX_D) && !m_hit) begin sd = 1; m_hit = 1; end
        m_dwell = (m_dwell + 1 > 63) ? 63 : m_dwell + 1;
      end else if (idx == (m_ph + 1) % 3) begin
        if (m_dwell < int'(MIN_D)) sd = 1;
        if (m_ph == 2) m_cycles = (m_cycles + 1) % 256;
        m_ph = idx; m_dwell = 1; m_hit = 0;
      end else begin
        ss = 1; m_mode = 2; m_dwell = 0;
      end
    end else begin
      if (c) m_mode = 0;
    end
    m_ec = sc | (m_ec & !c);
    m_es = ss | (m_es & !c);
`ifdef DWELL_CHECK_EN
    m_ed = sd | (m_ed & !c);
`else
    m_ed = 0;
`endif
  endtask

  function automatic logic [21:0] model_vec();
    logic [2:0] ph;
    ph = (m_mode == 1) ? 3'(1 << m_ph) : 3'b000;
    return {ph, (m_mode == 1), m_ec, m_es, m_ed, 8'(m_cycles), 6'(m_dwell)};
  endfunction

  function automatic logic [21:0] dut_vec();
    return {bus.phase_o, bus.locked_o, bus.err_code_o, bus.err_seq_o, bus.err_dwell_o,
            bus.cycles_o, bus.dwell_o};
  endfunction

  task automatic step(input logic [2:0] l, input logic c);
    bus.lights  = l;
    bus.clear_i = c;
    @(posedge clock);
    #1;
    model_step(l, c);
    bus.clear_i = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.lights = 3'b000;
    bus.clear_i = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (dut_vec() !== 22'd0) begin
      errors++;
      $display("FAIL reset_state: got %h expected 0", dut_vec());
    end
  endtask

  task automatic test_full_cycles();
    logic [2:0] seq [7];
    seq = '{G, Y, R, G, Y, R, G};
    do_reset();
    foreach (seq[i]) begin
      step(seq[i], 1'b0);
      checks++;
      if (bus.locked_o !== 1'b1 || bus.dwell_o !== 6'd1 || bus.phase_o !== seq[i] ||
          bus.err_code_o !== 1'b0 || bus.err_seq_o !== 1'b0) begin
        errors++;
        $display("FAIL full_cycle[%0d]: locked=%b dwell=%0d phase=%b ec=%b es=%b expected 1/1/%b/0/0",
                 i, bus.locked_o, bus.dwell_o, bus.phase_o, bus.err_code_o, bus.err_seq_o, seq[i]);
      end
    end
    checks++;
    if (bus.cycles_o !== 8'd2) begin
      errors++;
      $display("FAIL full_cycle_count: got %0d expected 2", bus.cycles_o);
    end
  endtask

  task automatic test_dwell_count();
    logic [2:0] seq [4];
    logic [5:0] exp_d [4];
    seq   = '{G, G, G, Y};
    exp_d = '{6'd1, 6'd2, 6'd3, 6'd1};
    do_reset();
    foreach (seq[i]) begin
      step(seq[i], 1'b0);
      checks++;
      if (bus.dwell_o !== exp_d[i] || bus.phase_o !== seq[i]) begin
        errors++;
        $display("FAIL dwell_count[%0d]: dwell=%0d phase=%b expected %0d/%b",
                 i, bus.dwell_o, bus.phase_o, exp_d[i], seq[i]);
      end
    end
  endtask

  task automatic test_seq_error();
    do_reset();
    step(G, 1'b0);
    step(R, 1'b0);
    checks++;
    if (bus.err_seq_o !== 1'b1 || bus.phase_o !== 3'b000 || bus.locked_o !== 1'b0 || bus.dwell_o !== 6'd0) begin
      errors++;
      $display("FAIL seq_error: es=%b phase=%b locked=%b dwell=%0d expected 1/000/0/0",
               bus.err_seq_o, bus.phase_o, bus.locked_o, bus.dwell_o);
    end
    step(R, 1'b1);
    checks++;
    if (bus.err_seq_o !== 1'b0 || bus.locked_o !== 1'b0 || bus.cycles_o !== 8'd0) begin
      errors++;
      $display("FAIL seq_clear: es=%b locked=%b cycles=%0d expected 0/0/0",
               bus.err_seq_o, bus.locked_o, bus.cycles_o);
    end
    step(R, 1'b0);
    checks++;
    if (bus.phase_o !== R || bus.locked_o !== 1'b1) begin
      errors++;
      $display("FAIL seq_relock: phase=%b locked=%b expected 100/1", bus.phase_o, bus.locked_o);
    end
  endtask

  task automatic test_code_error();
    do_reset();
    step(G, 1'b0);
    step(3'b011, 1'b0);
    checks++;
    if (bus.err_code_o !== 1'b1 || bus.locked_o !== 1'b0 || bus.phase_o !== 3'b000) begin
      errors++;
      $display("FAIL code_error: ec=%b locked=%b phase=%b expected 1/0/000",
               bus.err_code_o, bus.locked_o, bus.phase_o);
    end
    step(3'b011, 1'b1);
    checks++;
    if (bus.err_code_o !== 1'b0) begin
      errors++;
      $display("FAIL code_clear: ec=%b expected 0", bus.err_code_o);
    end
    step(3'b011, 1'b0);
    checks++;
    if (bus.err_code_o !== 1'b1 || bus.locked_o !== 1'b0) begin
      errors++;
      $display("FAIL code_reassert: ec=%b locked=%b expected 1/0", bus.err_code_o, bus.locked_o);
    end
    // Error detected in the same cycle as clear: the error must win.
    step(3'b111, 1'b1);
    checks++;
    if (bus.err_code_o !== 1'b1) begin
      errors++;
      $display("FAIL code_vs_clear: ec=%b expected 1", bus.err_code_o);
    end
  endtask

`ifdef DWELL_CHECK_EN
  task automatic test_dwell_limits();
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      step(G, 1'b0);
      checks++;
      if (bus.err_dwell_o !== (i >= 5) || bus.locked_o !== 1'b1 || bus.dwell_o !== 6'(i)) begin
        errors++;
        $display("FAIL dwell_max[%0d]: ed=%b locked=%b dwell=%0d expected %b/1/%0d",
                 i, bus.err_dwell_o, bus.locked_o, bus.dwell_o, (i >= 5), i);
      end
    end
    do_reset();
    step(G, 1'b0);
    step(Y, 1'b0);
    checks++;
    if (bus.err_dwell_o !== 1'b1 || bus.locked_o !== 1'b1 || bus.phase_o !== Y) begin
      errors++;
      $display("FAIL dwell_min: ed=%b locked=%b phase=%b expected 1/1/010",
               bus.err_dwell_o, bus.locked_o, bus.phase_o);
    end
  endtask
`endif

  task automatic test_wrap_and_async_reset();
    do_reset();
    step(G, 1'b0);
    for (int n = 0; n < 256; n++) begin
      step(Y, 1'b0);
      step(R, 1'b0);
      step(G, 1'b0);
      if (n == 254) begin
        checks++;
        if (bus.cycles_o !== 8'd255) begin
          errors++;
          $display("FAIL wrap_pre: cycles=%0d expected 255", bus.cycles_o);
        end
      end
    end
    checks++;
    if (bus.cycles_o !== 8'd0 || dut_vec() !== model_vec()) begin
      errors++;
      $display("FAIL wrap: cycles=%0d vec=%h expected 0 / %h", bus.cycles_o, dut_vec(), model_vec());
    end
    step(Y, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (dut_vec() !== 22'd0) begin
      errors++;
      $display("FAIL async_reset: got %h expected 0", dut_vec());
    end
    #3;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    logic [2:0] l;
    logic       c;
    int         r;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(99));
      if (m_mode == 1 && r < 55)      l = 3'(1 << ((m_ph + 1) % 3));
      else if (m_mode == 1 && r < 85) l = 3'(1 << m_ph);
      else if (r < 92)                l = 3'($urandom_range(7));
      else                            l = 3'(1 << $urandom_range(2));
      c = ($urandom_range(19) == 0);
      step(l, c);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL random[%0d]: lights=%b clear=%b got %h expected %h",
                 i, l, c, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    bus.lights = 3'b000;
    bus.clear_i = 1'b0;
    model_reset();
    test_reset();
    test_full_cycles();
    test_dwell_count();
    test_seq_error();
    test_code_error();
`ifdef DWELL_CHECK_EN
    test_dwell_limits();
`endif
    test_wrap_and_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
